// File: rtl/rename_unit_pkg.sv
// Shared sizes and tag types for the rename stage: architectural index, physical tag
// and free-list geometry.
package rename_unit_pkg;

    localparam int ARCH_NUM = 64;
    localparam int PREG_NUM = 128;
    localparam int FL_DEPTH = PREG_NUM - ARCH_NUM;

    localparam int AREG_W  = $clog2(ARCH_NUM);
    localparam int PREG_W  = $clog2(PREG_NUM);
    localparam int FL_PTR_W = $clog2(FL_DEPTH);
    localparam int FL_CNT_W = FL_PTR_W + 1;

    typedef logic [AREG_W-1:0]   areg_t;
    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;

endpackage

// File: rtl/rename_unit_free_list.sv
// Circular free list of physical tags: pops at head, pushes at tail, and can rewind
// head by up to two slots to hand rolled-back tags back out in their original order.
module rename_unit_free_list
    import rename_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pop,
    input  logic       push,
    input  preg_t      push_tag,
    input  logic [1:0] rewind_n,
    output preg_t      head_tag,
    output fl_cnt_t    count
);

    preg_t   fl [FL_DEPTH];
    fl_ptr_t head;
    fl_ptr_t tail;

    assign head_tag = fl[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < FL_DEPTH; j++) begin
                fl[j] <= preg_t'(ARCH_NUM + j);
            end
            head  <= '0;
            tail  <= '0;
            count <= fl_cnt_t'(FL_DEPTH);
        end else begin
            if (push) begin
                fl[tail] <= push_tag;
                tail     <= tail + fl_ptr_t'(1);
            end
            // Pop and rewind are mutually exclusive (rewind only during recovery),
            // so a single adder covers both head moves.
            head  <= head + fl_ptr_t'(pop) - fl_ptr_t'(rewind_n);
            count <= count + fl_cnt_t'(push) + fl_cnt_t'(rewind_n) - fl_cnt_t'(pop);
        end
    end

endmodule

// File: rtl/rename_unit.sv
// Register rename stage: speculative alias table plus free-list management, with
// commit-time reclamation and two-per-cycle rollback of speculative mappings.
module rename_unit
    import rename_unit_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  ID_valid,
    input  areg_t ID_A_rs1,
    input  areg_t ID_A_rs2,
    input  areg_t ID_A_rd,
    input  logic  ID_rd_we,
    input  logic  DC_ready,
    output logic  rename_ready,
    output preg_t DC_P_rs1,
    output preg_t DC_P_rs2,
    output preg_t DC_P_rd_new,
    output preg_t DC_P_rd_old,
    input  logic  commit_wb_en,
    input  preg_t commit_P_rd_old,
    input  logic  stall,
    input  logic  rollback_en_0,
    input  areg_t rollback_A_rd_0,
    input  preg_t rollback_P_rd_old_0,
    input  preg_t rollback_P_rd_new_0,
    input  logic  rollback_en_1,
    input  areg_t rollback_A_rd_1,
    input  preg_t rollback_P_rd_old_1,
    input  preg_t rollback_P_rd_new_1,
    output fl_cnt_t free_count
);

    preg_t      rat [ARCH_NUM];
    preg_t      fl_head_tag;
    fl_cnt_t    fl_count;
    logic       need_alloc;
    logic       fire;
    logic       do_alloc;
    logic       do_push;
    logic       rb_valid_0;
    logic       rb_valid_1;
    logic       rb_free_0;
    logic       rb_free_1;
    logic [1:0] rb_n;

    assign need_alloc   = ID_rd_we && (ID_A_rd != '0);
    assign rename_ready = !stall && (!need_alloc || (fl_count != '0));
    assign fire         = ID_valid && DC_ready && rename_ready;
    assign do_alloc     = fire && need_alloc;
    assign do_push      = commit_wb_en && (commit_P_rd_old != '0);

    // Entry 1 is only meaningful behind entry 0; a lone en_1 is dropped.
    assign rb_valid_0 = stall && rollback_en_0;
    assign rb_valid_1 = stall && rollback_en_0 && rollback_en_1;
    assign rb_free_0  = rb_valid_0 && (rollback_P_rd_new_0 != '0);
    assign rb_free_1  = rb_valid_1 && (rollback_P_rd_new_1 != '0);
    assign rb_n       = {1'b0, rb_free_0} + {1'b0, rb_free_1};

    assign DC_P_rs1    = rat[ID_A_rs1];
    assign DC_P_rs2    = rat[ID_A_rs2];
    assign DC_P_rd_old = need_alloc ? rat[ID_A_rd] : '0;
    assign DC_P_rd_new = need_alloc ? fl_head_tag  : '0;
    assign free_count  = fl_count;

    // Entry 1 is older, so it is written last and wins on a shared A_rd.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_NUM; i++) begin
                rat[i] <= preg_t'(i);
            end
        end else begin
            if (do_alloc) begin
                rat[ID_A_rd] <= fl_head_tag;
            end
            if (rb_valid_0 && (rollback_A_rd_0 != '0)) begin
                rat[rollback_A_rd_0] <= rollback_P_rd_old_0;
            end
            if (rb_valid_1 && (rollback_A_rd_1 != '0)) begin
                rat[rollback_A_rd_1] <= rollback_P_rd_old_1;
            end
        end
    end

    rename_unit_free_list u_free_list (
        .clk      (clk),
        .rst      (rst),
        .pop      (do_alloc),
        .push     (do_push),
        .push_tag (commit_P_rd_old),
        .rewind_n (rb_n),
        .head_tag (fl_head_tag),
        .count    (fl_count)
    );

endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register-rename stage feeding dispatch. Holds the speculative register alias table (RAT, 64 architectural → 7-bit physical) and the physical-register free list.
- Each renamed instruction gets source physical tags, a newly allocated destination tag (DC_P_rd_new) and the destination's previous mapping (DC_P_rd_old).
- Reclaims P_rd_old on ROB commit.
- Undoes speculative mappings from the ROB's two-per-cycle walk-back rollback stream.

Parameters:
- ARCH_NUM, 64, architectural registers (x0-x31, f0-f31); A-index width 6.
- PREG_NUM, 128, physical registers; P-tag width 7; P0 is hardwired zero / "no destination".
- FL_DEPTH, PREG_NUM-ARCH_NUM (64), free-list slots; must be a power of 2.

Ports:
- clk in 1: clock.
- rst in 1: synchronous, active-high reset.
- ID_valid in 1: decoded instruction present.
- ID_A_rs1 in 6: source 1 architectural index.
- ID_A_rs2 in 6: source 2 architectural index.
- ID_A_rd in 6: destination architectural index.
- ID_rd_we in 1: instruction writes a destination.
- DC_ready in 1: downstream (ROB/IQ) can accept this cycle.
- rename_ready out 1: rename can accept this cycle.
- DC_P_rs1 out 7: physical tag of source 1.
- DC_P_rs2 out 7: physical tag of source 2.
- DC_P_rd_new out 7: newly allocated destination tag.
- DC_P_rd_old out 7: previous mapping of the destination.
- commit_wb_en in 1: ROB commit of an instruction with a destination.
- commit_P_rd_old in 7: physical register to free.
- stall in 1: ROB in recovery.
- rollback_en_0 / rollback_A_rd_0 / rollback_P_rd_old_0 / rollback_P_rd_new_0 in 1/6/7/7: youngest rolled-back entry.
- rollback_en_1 / rollback_A_rd_1 / rollback_P_rd_old_1 / rollback_P_rd_new_1 in 1/6/7/7: next-older rolled-back entry.
- free_count out 7: free-list occupancy, 0..64.

Behaviour:
- Reset: RAT[i]=i for all i; fl[j]=ARCH_NUM+j; head=0, tail=0, count=FL_DEPTH. Outputs then: free_count=64, rename_ready=!stall.
- need_alloc = ID_rd_we && ID_A_rd!=0.
- rename_ready = !stall && (!need_alloc || count!=0).
- fire = ID_valid && DC_ready && rename_ready.
- DC_P_rs1/2 = RAT[ID_A_rs1/2], combinational from current RAT.
  - A RAT write lands at the clock edge and is visible to the next instruction.
  - No same-cycle bypass; single-issue.
- DC_P_rd_old = need_alloc ? RAT[ID_A_rd] : 0.
- DC_P_rd_new = need_alloc ? fl[head] : 0.
- Both outputs are combinational and valid whenever ID_valid.
- On fire && need_alloc: RAT[ID_A_rd] <= fl[head]; head+1; count-1. Latency 0 (tags in the same cycle), state updates at the edge.
- RAT[0] is never written and always reads 0.
- Commit: if commit_wb_en && commit_P_rd_old!=0, then fl[tail] <= commit_P_rd_old, tail+1, count+1. This is independent of stall.
- Rollback (only while stall; no allocation occurs then):
  - n = (en_0 && P_rd_new_0!=0) + (en_0 && en_1 && P_rd_new_1!=0).
  - head <= head-n; count += n.
  - Slots head-1..head-n still hold the rolled-back tags, because allocation is FIFO and rollback runs youngest-first.
  - RAT[A_rd_0] <= P_rd_old_0 if en_0 && A_rd_0!=0.
  - RAT[A_rd_1] <= P_rd_old_1 if en_0 && en_1 && A_rd_1!=0.
  - If A_rd_0==A_rd_1, entry 1 (older) wins.
  - en_1 without en_0 is ignored.
- Simultaneous events: commit push, rollback, and allocation adjust count additively: count_next = count + push + n - pop.
  - Pointers wrap modulo FL_DEPTH.
  - tail and head never touch the same slot in one cycle.
- Boundaries:
  - count==0 blocks only rd-writing instructions.
  - count overflow beyond FL_DEPTH or underflow is illegal; the bench asserts on it.
  - rst mid-recovery restores the full reset state in one cycle.

Decomposition:
- Shared package: ARCH_NUM, PREG_NUM, FL_DEPTH, and the preg_t (7b) / areg_t (6b) typedefs.
- Sub-module free_list (circular buffer):
  - pop port;
  - one push port;
  - rewind-by-n (0..2) port;
  - count output.
- The RAT stays in rename_unit.

Test Plan:
- Reset; rename x5 (rd_we) → P_rd_new=64, P_rd_old=5. Next cycle rename rd=x5, rs1=x5 → P_rs1=64, P_rd_new=65, P_rd_old=64; free_count=62.
- rd=x0 with rd_we=1 → P_rd_new=0, P_rd_old=0, free_count unchanged at 64. Source x0 → P_rs1=0.
- 64 allocations → free_count=0, rename_ready=0 for rd-writing and 1 for rd_we=0. Then commit_wb_en with P_rd_old=5 → rename_ready=1, next P_rd_new=5.
- Allocate x5→64, x6→65, x5→66, then stall. Rollback pair (A5 old64 new66; A6 old6 new65), then single (A5 old5 new64) → RAT[5]=5, RAT[6]=6, free_count=64; after stall drops, next alloc=64.
- Rollback pair with equal A_rd: en_0 A7 old67 new68, en_1 A7 old7 new67 → RAT[7]=7, head rewinds by 2.
- Same cycle: commit push of P9 plus rollback n=2 with free_count=60 → free_count=63; fl[old tail]=9.
